demux_7_32b_reg: RTL

Registered 1-to-7 distributor for 32-bit words: the write-side counterpart of the 7-input word selector in the datapath. A word presented with a 3-bit selector is captured, then committed to one of seven held output lanes, with a one-cycle write strobe per lane. Selector code 7 clears every lane, mirroring the selector's all-zeros code 7. It sits between the control unit's write-back path and the destination registers that need a stable held copy and an update pulse.

---
 rtl/demux_7_32b_reg_if.sv | 29 ++
 rtl/demux_7_32b_reg.sv | 90 +++++++++
 2 files changed

// File: rtl/demux_7_32b_reg_if.sv
// Request/lane bundle for the registered 1-to-7 word distributor.
// master = requester driving words in; slave = the distributor itself.
interface demux_7_32b_reg_if;
    logic        in_valid;
    logic [2:0]  selector;
    logic [31:0] in_data;
    logic        in_ready;
    logic [31:0] out_0, out_1, out_2, out_3, out_4, out_5, out_6;
    logic        wr_0, wr_1, wr_2, wr_3, wr_4, wr_5, wr_6;
    logic [6:0]  lane_valid;
    logic        clr_done;
    logic [7:0]  write_count;

    modport master (
        output in_valid, selector, in_data,
        input  in_ready,
        input  out_0, out_1, out_2, out_3, out_4, out_5, out_6,
        input  wr_0, wr_1, wr_2, wr_3, wr_4, wr_5, wr_6,
        input  lane_valid, clr_done, write_count
    );

    modport slave (
        input  in_valid, selector, in_data,
        output in_ready,
        output out_0, out_1, out_2, out_3, out_4, out_5, out_6,
        output wr_0, wr_1, wr_2, wr_3, wr_4, wr_5, wr_6,
        output lane_valid, clr_done, write_count
    );
endinterface

// File: rtl/demux_7_32b_reg.sv
// Registered 1-to-7 distributor: capture stage S1, commit stage S2 into seven
// held 32-bit lanes with per-lane write strobes; selector 7 clears all lanes.
module demux_7_32b_reg (
    input  logic                clk,
    input  logic                reset,
    demux_7_32b_reg_if.slave    bus
);
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;
    localparam logic [2:0] SEL_CLEAR = 3'b111;

    logic [0:0]  state;
    logic        s1_full;
    logic [2:0]  s1_sel;
    logic [31:0] s1_data;
    logic [31:0] lanes [7];
    logic [6:0]  wr;
    logic [6:0]  lane_valid;
    logic        clr_done;
    logic [7:0]  write_count;
    logic        accept;
    logic        commit_clear;

    assign bus.in_ready  = (state == RUN);
    assign accept        = bus.in_valid && (state == RUN);
    assign commit_clear  = s1_full && (s1_sel == SEL_CLEAR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_full <= 1'b0;
            s1_sel  <= '0;
            s1_data <= '0;
        end else begin
            s1_full <= accept;
            if (accept) begin
                s1_sel  <= bus.selector;
                s1_data <= bus.in_data;
            end
        end
    end

    // S2 drains S1 every edge, even in CLEAR, so a word captured alongside a
    // clear commit lands on the edge that leaves CLEAR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wr          <= '0;
            lane_valid  <= '0;
            clr_done    <= 1'b0;
            write_count <= '0;
            for (int unsigned i = 0; i < 7; i++) lanes[i] <= '0;
        end else begin
            wr       <= '0;
            clr_done <= 1'b0;
            state    <= commit_clear ? CLEAR : RUN;
            if (commit_clear) begin
                for (int unsigned i = 0; i < 7; i++) lanes[i] <= '0;
                lane_valid <= '0;
                clr_done   <= 1'b1;
            end else if (s1_full) begin
                for (int unsigned i = 0; i < 7; i++) begin
                    if (s1_sel == 3'(i)) begin
                        lanes[i]      <= s1_data;
                        wr[i]         <= 1'b1;
                        lane_valid[i] <= 1'b1;
                    end
                end
                if (write_count != 8'hFF) write_count <= write_count + 8'd1;
            end
        end
    end

    assign bus.out_0 = lanes[0];
    assign bus.out_1 = lanes[1];
    assign bus.out_2 = lanes[2];
    assign bus.out_3 = lanes[3];
    assign bus.out_4 = lanes[4];
    assign bus.out_5 = lanes[5];
    assign bus.out_6 = lanes[6];
    assign bus.wr_0  = wr[0];
    assign bus.wr_1  = wr[1];
    assign bus.wr_2  = wr[2];
    assign bus.wr_3  = wr[3];
    assign bus.wr_4  = wr[4];
    assign bus.wr_5  = wr[5];
    assign bus.wr_6  = wr[6];
    assign bus.lane_valid  = lane_valid;
    assign bus.clr_done    = clr_done;
    assign bus.write_count = write_count;
endmodule
